// File: rtl/elastic_pipe.sv
// Elastic pipeline register chain.
// Each stage pairs a main register with a skid register so every ready is a flop output and
// back-pressure never ripples combinationally through the chain. Adds a global hold, a flush
// that drops every entry, and a registered occupancy count.
module elastic_pipe #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 2,
   parameter int unsigned CW     = $clog2(2 * STAGES + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             hold,
   input  logic             flush,
   output logic [CW-1:0]    occupancy
);

   // Per-stage state
   logic [STAGES-1:0] m_valid_q, m_valid_d;
   logic [STAGES-1:0] s_valid_q, s_valid_d;
   logic [WIDTH-1:0]  m_data_q [STAGES];
   logic [WIDTH-1:0]  m_data_d [STAGES];
   logic [WIDTH-1:0]  s_data_q [STAGES];
   logic [WIDTH-1:0]  s_data_d [STAGES];
   logic [CW-1:0]     occ_q, occ_d;

   // Per-stage handshake view
   logic [STAGES-1:0] up_valid;
   logic [WIDTH-1:0]  up_data [STAGES];
   logic [STAGES-1:0] dn_ready;
   logic [STAGES-1:0] xfer_in;
   logic [STAGES-1:0] xfer_out;

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      if (g == 0) begin : g_head
         assign up_valid[g] = in_valid;
         assign up_data[g]  = in_data;
      end else begin : g_body
         assign up_valid[g] = m_valid_q[g-1];
         assign up_data[g]  = m_data_q[g-1];
      end

      if (g == STAGES - 1) begin : g_tail
         assign dn_ready[g] = out_ready;
      end else begin : g_inner
         // Downstream readiness is the next stage's registered skid-empty flag.
         assign dn_ready[g] = ~s_valid_q[g+1];
      end

      assign xfer_in[g]  = up_valid[g] & ~s_valid_q[g];
      assign xfer_out[g] = m_valid_q[g] & dn_ready[g];
   end

   // Next-state for every stage's main/skid registers, then hold and flush overrides
   always_comb begin
      m_valid_d = m_valid_q;
      s_valid_d = s_valid_q;
      m_data_d  = m_data_q;
      s_data_d  = s_data_q;
      if (!hold) begin
         for (int unsigned i = 0; i < STAGES; i++) begin
            if (!m_valid_q[i] || xfer_out[i]) begin
               // Main slot is free this edge: refill from skid first to keep FIFO order.
               if (s_valid_q[i]) begin
                  m_valid_d[i] = 1'b1;
                  m_data_d[i]  = s_data_q[i];
               end else if (xfer_in[i]) begin
                  m_valid_d[i] = 1'b1;
                  m_data_d[i]  = up_data[i];
               end else begin
                  m_valid_d[i] = 1'b0;
               end
               s_valid_d[i] = 1'b0;
            end else if (xfer_in[i]) begin
               // Main is stalled: the beat accepted on the registered ready parks in the skid.
               s_valid_d[i] = 1'b1;
               s_data_d[i]  = up_data[i];
            end
         end
      end
      // Flush overrides hold.
      if (flush) begin
         m_valid_d = '0;
         s_valid_d = '0;
      end
   end

   // Occupancy of the next state, so the count lands in the same edge as the valid bits
   always_comb begin
      occ_d = '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
         occ_d = occ_d + CW'(m_valid_d[i]) + CW'(s_valid_d[i]);
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_valid_q <= '0;
         s_valid_q <= '0;
         occ_q     <= '0;
         for (int unsigned i = 0; i < STAGES; i++) begin
            m_data_q[i] <= '0;
            s_data_q[i] <= '0;
         end
      end else begin
         m_valid_q <= m_valid_d;
         s_valid_q <= s_valid_d;
         occ_q     <= occ_d;
         for (int unsigned i = 0; i < STAGES; i++) begin
            m_data_q[i] <= m_data_d[i];
            s_data_q[i] <= s_data_d[i];
         end
      end
   end

   // Outputs are flops; only hold gates the handshake strobes so no transfer is seen
   always_comb begin
      in_ready  = ~s_valid_q[0] & ~hold;
      out_valid = m_valid_q[STAGES-1] & ~hold;
      out_data  = m_data_q[STAGES-1];
      occupancy = occ_q;
   end

endmodule

// File: tb/tb_elastic_pipe.sv
// Bench for elastic_pipe: cycle table for stream/back-pressure/hold/flush, hand sequences
// for reset and latency, and a random phase; a queue scoreboard checks every output beat.
module tb_elastic_pipe;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned STAGES = 2;
   localparam int unsigned CW     = 3;
   localparam int unsigned CAP    = 2 * STAGES;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic             hold = 1'b0;
   logic             flush = 1'b0;
   logic [CW-1:0]    occupancy;

   int n_vec = 0;
   int n_err = 0;
   int n_out = 0;
   logic [WIDTH-1:0] sb_q [$];

   elastic_pipe #(
      .WIDTH (WIDTH),
      .STAGES(STAGES),
      .CW    (CW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .hold     (hold),
      .flush    (flush),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: occupancy must equal entries accepted and not yet delivered or flushed
   always @(negedge clk) begin
      if (!reset) begin
         sb_q.delete();
      end else begin
         chk("occupancy", 32'(occupancy), 32'(sb_q.size()));
         if (!hold && occupancy == 0) chk("in_ready_empty", 32'(in_ready), 32'd1);
         if (occupancy == CW'(CAP)) chk("in_ready_full", 32'(in_ready), 32'd0);
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) chk("out_beat_expected", 32'(out_valid), 32'd0);
            else begin
               chk("out_data", out_data, sb_q.pop_front());
               n_out++;
            end
         end
         if (in_valid && in_ready && !flush) sb_q.push_back(in_data);
         if (flush) sb_q.delete();
      end
   end

   typedef struct {
      logic          iv;
      logic [31:0]   d;
      logic          ordy;
      logic          hld;
      logic          fl;
      logic          e_irdy;
      logic          e_ov;
      logic [CW-1:0] e_occ;
   } vec_t;

   function automatic vec_t mk(input logic iv, input logic [31:0] d, input logic ordy,
                               input logic hld, input logic fl, input logic e_irdy,
                               input logic e_ov, input logic [CW-1:0] e_occ);
      vec_t v;
      v.iv = iv; v.d = d; v.ordy = ordy; v.hld = hld; v.fl = fl;
      v.e_irdy = e_irdy; v.e_ov = e_ov; v.e_occ = e_occ;
      return v;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl [22];
      int   n0;
      int   lat;
      bit   seen;

      // in_valid, data, out_ready, hold, flush | in_ready, out_valid, occupancy (this cycle)
      tbl[0]  = mk(1, 1,  1, 0, 0, 1, 0, 0);
      tbl[1]  = mk(1, 2,  1, 0, 0, 1, 0, 1);
      tbl[2]  = mk(1, 3,  1, 0, 0, 1, 1, 2);
      tbl[3]  = mk(1, 4,  1, 0, 0, 1, 1, 2);
      tbl[4]  = mk(1, 5,  0, 0, 0, 1, 1, 2);
      tbl[5]  = mk(1, 6,  0, 0, 0, 1, 1, 3);
      tbl[6]  = mk(1, 7,  0, 0, 0, 0, 1, 4);
      tbl[7]  = mk(1, 7,  0, 0, 0, 0, 1, 4);
      tbl[8]  = mk(1, 7,  1, 1, 0, 0, 0, 4);
      tbl[9]  = mk(0, 0,  1, 0, 0, 0, 1, 4);
      tbl[10] = mk(0, 0,  1, 0, 0, 0, 1, 3);
      tbl[11] = mk(1, 8,  0, 0, 0, 1, 1, 2);
      tbl[12] = mk(1, 9,  1, 0, 1, 1, 1, 3);
      tbl[13] = mk(0, 0,  1, 0, 0, 1, 0, 0);
      tbl[14] = mk(1, 10, 0, 0, 0, 1, 0, 0);
      tbl[15] = mk(1, 11, 0, 0, 0, 1, 0, 1);
      tbl[16] = mk(1, 12, 1, 1, 1, 0, 0, 2);
      tbl[17] = mk(0, 0,  1, 0, 0, 1, 0, 0);
      tbl[18] = mk(1, 13, 1, 0, 0, 1, 0, 0);
      tbl[19] = mk(0, 0,  1, 0, 0, 1, 0, 1);
      tbl[20] = mk(0, 0,  1, 0, 0, 1, 1, 1);
      tbl[21] = mk(0, 0,  1, 0, 0, 1, 0, 0);

      // Reset values while reset is held low
      #2;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_occupancy", 32'(occupancy), 0);
      chk("rst_out_data", out_data, 0);
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      @(posedge clk); #1;

      for (int j = 0; j < 22; j++) begin
         in_valid = tbl[j].iv; in_data = tbl[j].d; out_ready = tbl[j].ordy;
         hold = tbl[j].hld; flush = tbl[j].fl;
         @(negedge clk);
         chk($sformatf("tbl%0d_in_ready", j), 32'(in_ready), 32'(tbl[j].e_irdy));
         chk($sformatf("tbl%0d_out_valid", j), 32'(out_valid), 32'(tbl[j].e_ov));
         chk($sformatf("tbl%0d_occupancy", j), 32'(occupancy), 32'(tbl[j].e_occ));
         @(posedge clk); #1;
      end
      in_valid = 1'b0; hold = 1'b0; flush = 1'b0;

      // Stream 1..16 at full rate, with a 3-cycle hold before beat 8
      n0 = n_out;
      out_ready = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         in_valid = 1'b1; in_data = k;
         if (k == 8) begin
            hold = 1'b1;
            repeat (3) begin
               @(negedge clk);
               chk("hold_out_valid", 32'(out_valid), 0);
               chk("hold_in_ready", 32'(in_ready), 0);
               chk("hold_occupancy", 32'(occupancy), 2);
               @(posedge clk); #1;
            end
            hold = 1'b0;
         end
         @(negedge clk);
         chk("stream_in_ready", 32'(in_ready), 1);
         if (k >= 3) chk("stream_occupancy", 32'(occupancy), 2);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      for (int t = 0; t < 20 && occupancy != 0; t++) begin
         @(posedge clk); #1;
      end
      chk("stream_count", n_out - n0, 16);

      // Fill the chain, then assert reset between edges
      out_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         in_valid = 1'b1; in_data = 32'h100 + k;
         @(posedge clk); #1;
      end
      chk("full_occupancy", 32'(occupancy), CAP);
      #1 reset = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 0);
      chk("midrst_in_ready", 32'(in_ready), 1);
      chk("midrst_occupancy", 32'(occupancy), 0);
      chk("midrst_out_data", out_data, 0);
      @(posedge clk);
      #3 reset = 1'b1;

      // Single-beat latency through an empty chain
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 32'h5A5A0001; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
         else begin
            @(posedge clk); #1;
            lat++;
         end
      end
      chk("latency", lat, STAGES);
      @(posedge clk); #1;

      // Random valid/ready/hold/flush against the scoreboard
      for (int c = 0; c < 3000; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = $urandom;
         out_ready = ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                          : ($urandom_range(0, 3) == 0);
         hold      = ($urandom_range(0, 15) == 0);
         flush     = ($urandom_range(0, 63) == 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; hold = 1'b0; flush = 1'b0; out_ready = 1'b1;
      for (int t = 0; t < 20 && occupancy != 0; t++) begin
         @(posedge clk); #1;
      end
      chk("drain_scoreboard", 32'(sb_q.size()), 0);
      chk("drain_occupancy", 32'(occupancy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/elastic_pipe.md
# elastic_pipe

Parametrised elastic pipeline register chain that replaces the bare per-signal flip-flops between core stages. It carries a WIDTH-bit payload through STAGES register stages under a valid/ready handshake. Each stage has a skid buffer, so all ready outputs are registered and back-pressure never forms a combinational path through the chain. It adds a global hold (memory-system stall), a synchronous flush (branch/jump kill) and an occupancy count, none of which the plain pipeline flip-flops provide.

## Interface
Parameters:
- WIDTH, 32, payload bits per entry (≥1)
- STAGES, 2, number of register stages (≥1); capacity = 2*STAGES entries
- CW, $clog2(2*STAGES+1), width of occupancy

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; clears all state while low
- in_valid  input  1  upstream offers in_data
- in_ready  output  1  stage 0 can accept; registered
- in_data  input  WIDTH  payload
- out_valid  output  1  last stage holds an entry
- out_ready  input  1  downstream accepts
- out_data  output  WIDTH  last stage payload
- hold  input  1  global stall: freezes all state
- flush  input  1  discard every entry
- occupancy  output  CW  count of valid entries (main + skid, all stages)

## Operation
- Stage i: main register M_i (valid, data), skid register S_i (valid, data). Stage i upstream ready = !S_i.valid. Stage i presents M_i downstream. Stage 0 upstream = in_*, stage STAGES-1 downstream = out_*.
- Transfer into stage i on an edge when upstream valid and !S_i.valid (and hold low). Transfer out when M_i.valid and downstream ready.
- Per-edge update of stage i:
  - M_i empty or leaving: M_i <- S_i if S_i.valid, else incoming if transferring in, else invalid; S_i <- incoming if S_i was valid and transferring in (cannot occur: S_i valid blocks input), else invalid.
  - M_i valid and staying: if transferring in, S_i <- incoming; M_i unchanged.
- Order strictly FIFO; no entry duplicated or dropped except by flush.
- Bubbles collapse: an invalid M_i accepts even when downstream is stalled.
- hold=1: no register changes; in_ready and out_valid forced 0 combinationally for the cycle so neither side sees a transfer.
- flush=1 (hold=0): all M/S valid bits cleared at the edge; an in_valid beat offered that cycle is dropped; an out beat handshaken that cycle counts as delivered. hold and flush both high: flush wins, valids cleared.
- occupancy = popcount of all valid bits, registered alongside them.
- Reset low: all valid bits, data registers and occupancy go to 0 immediately; in_ready=1 after reset (registered as !S_0.valid), out_valid=0, out_data=0, occupancy=0. Reset asserted mid-transfer drops all entries.

## Timing
- Latency: accepted beat appears on out_valid STAGES cycles later when the chain is empty and out_ready is high.
- Throughput: 1 beat/cycle sustained with out_ready high.
- With out_ready held low, in_ready falls after 2*STAGES accepted beats (full); it rises the cycle after out_ready is seen high for one beat at the head of a full chain and the freed slot propagates back, at most STAGES cycles.
- in_ready, out_valid, out_data, occupancy are register outputs except the hold gating.
- No combinational path out_ready -> in_ready.

## Test plan
- Streaming, WIDTH=32, STAGES=2: push 0x1..0x10 back-to-back, out_ready=1 -> first out_valid 2 cycles after first accept, 16 beats in order, occupancy steady at 2.
- Back-pressure: out_ready=0, push continuously -> exactly 4 beats accepted, in_ready=0, occupancy=4; release out_ready -> 4 beats out in order, no loss.
- Random valid/ready (10k cycles, STAGES=1,3) against scoreboard -> in-order, no drop/dup, occupancy matches model each cycle.
- hold pulse of 3 cycles mid-stream -> no transfers, state unchanged, stream resumes identically.
- flush with 3 entries plus concurrent in_valid -> next cycle occupancy=0, out_valid=0, flushed beat never appears.
- Assert reset low asynchronously between edges with full chain -> outputs 0 / in_ready=1 immediately after reset release, first new beat emerges after STAGES cycles.
